// File: rtl/mppt_po_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mppt_po_sequencer
// Brief   : Perturb-and-observe MPPT controller. Requests an ADC conversion,
//           forms P = V*I, compares against the previous power and steps the
//           duty command (with saturation) in the direction that raised power.
//           All registers update on the falling edge of clk.
// Options : MPPT_DEADBAND_EN - treat |P - P_prev| <= DEADBAND as "equal".
// Revision: 1.0 - initial release
// ============================================================================
module mppt_po_sequencer #(
  parameter int DW        = 12,
  parameter int DUTY_W    = 10,
  parameter int DUTY_INIT = 512,
  parameter int DUTY_MIN  = 64,
  parameter int DUTY_MAX  = 960,
  parameter int STEP      = 4,
  parameter int SETTLE    = 255,
  parameter int DEADBAND  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DW-1:0]     adc_v,
  input  logic [DW-1:0]     adc_i,
  input  logic              adc_valid,
  output logic              adc_req,
  output logic [DUTY_W-1:0] duty,
  output logic              dir,
  output logic [2:0]        state,
  output logic [1:0]        flag,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_ADC = 3'd2,
    S_CALC     = 3'd3,
    S_COMPARE  = 3'd4,
    S_UPDATE   = 3'd5,
    S_SETTLE   = 3'd6,
    S_UNUSED   = 3'd7
  } state_t;

  localparam int                 CNT_W          = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int                 PW             = 2 * DW;
  localparam logic [CNT_W-1:0]   C_SETTLE       = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0]   C_ONE          = CNT_W'(1);
  localparam logic [DUTY_W-1:0]  C_DUTY_INIT    = DUTY_W'(DUTY_INIT);
  localparam logic [DUTY_W-1:0]  C_DUTY_MIN     = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0]  C_DUTY_MAX     = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0]  C_STEP_N       = DUTY_W'(STEP);
  localparam logic [DUTY_W:0]    C_STEP_W       = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W:0]    C_MAX_W        = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W:0]    C_MIN_PLUS_STEP = (DUTY_W+1)'(DUTY_MIN + STEP);

  // Elaboration guard: a zero settle interval would never leave SETTLE cleanly.
  if ((SETTLE < 1) || (DEADBAND < 0)) begin : g_param_check
    $error("mppt_po_sequencer: SETTLE must be >= 1 and DEADBAND >= 0");
  end

  state_t            state_q, state_d;
  logic [DW-1:0]     v_q, v_d, i_q, i_d;
  logic [PW-1:0]     p_q, p_d, p_prev_q, p_prev_d;
  logic              first_q, first_d, was_first_q, was_first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;
  logic [1:0]        flag_q, flag_d;
  logic              adc_req_q, adc_req_d;
  logic              busy_q, busy_d;

  logic [DUTY_W:0]   w_up;
  logic [DUTY_W-1:0] w_dn;
  logic              w_dn_under;
  logic              w_in_band;
  logic              w_do_step;

  // Candidate duty values; the upward sum keeps a carry bit so it cannot wrap.
  assign w_up       = {1'b0, duty_q} + C_STEP_W;
  assign w_dn       = duty_q - C_STEP_N;
  assign w_dn_under = ({1'b0, duty_q} < C_MIN_PLUS_STEP);
  // A flag of 00 on a non-first sample means "hold"; the very first sample always steps.
  assign w_do_step  = !((flag_q == 2'b00) && !was_first_q);

`ifdef MPPT_DEADBAND_EN
  logic [PW-1:0] w_abs_diff;
  assign w_abs_diff = (p_q >= p_prev_q) ? (p_q - p_prev_q) : (p_prev_q - p_q);
  assign w_in_band  = (w_abs_diff <= PW'(DEADBAND));
`else
  assign w_in_band  = 1'b0;
`endif

  // Next-state and datapath decisions for one P&O iteration.
  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    i_d         = i_q;
    p_d         = p_q;
    p_prev_d    = p_prev_q;
    first_d     = first_q;
    was_first_d = was_first_q;
    cnt_d       = cnt_q;
    duty_d      = duty_q;
    dir_d       = dir_q;
    flag_d      = flag_q;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = en ? S_WAIT_ADC : S_IDLE;
      end
      S_WAIT_ADC: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (adc_valid) begin
          v_d     = adc_v;
          i_d     = adc_i;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!en) begin
          state_d = S_IDLE;
        end else begin
          p_d     = PW'(v_q) * PW'(i_q);
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (!en) begin
          state_d = S_IDLE;
        end else begin
          was_first_d = first_q;
          if (first_q) begin
            flag_d  = 2'b00;
            first_d = 1'b0;
          end else if (w_in_band) begin
            flag_d = 2'b00;
          end else if (p_q > p_prev_q) begin
            flag_d = 2'b01;
          end else if (p_q < p_prev_q) begin
            flag_d = 2'b10;
            dir_d  = ~dir_q;
          end else begin
            flag_d = 2'b00;
          end
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        // The duty write always completes here, even if en just fell.
        if (w_do_step) begin
          if (dir_q) begin
            if (w_up > C_MAX_W) begin
              duty_d = C_DUTY_MAX;
              dir_d  = 1'b0;
            end else begin
              duty_d = w_up[DUTY_W-1:0];
            end
          end else begin
            if (w_dn_under) begin
              duty_d = C_DUTY_MIN;
              dir_d  = 1'b1;
            end else begin
              duty_d = w_dn;
            end
          end
        end
        p_prev_d = p_q;
        cnt_d    = C_SETTLE;
        state_d  = en ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: begin
        if (!en) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          if (cnt_q != '0) cnt_d = cnt_q - C_ONE;
          if (cnt_q <= C_ONE) state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    adc_req_d = (state_d == S_REQ);
    busy_d    = (state_d != S_IDLE);
  end

  // Falling-edge state register; rst wins over everything.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      v_q         <= '0;
      i_q         <= '0;
      p_q         <= '0;
      p_prev_q    <= '0;
      first_q     <= 1'b1;
      was_first_q <= 1'b0;
      cnt_q       <= '0;
      duty_q      <= C_DUTY_INIT;
      dir_q       <= 1'b1;
      flag_q      <= 2'b00;
      adc_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      i_q         <= i_d;
      p_q         <= p_d;
      p_prev_q    <= p_prev_d;
      first_q     <= first_d;
      was_first_q <= was_first_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      flag_q      <= flag_d;
      adc_req_q   <= adc_req_d;
      busy_q      <= busy_d;
    end
  end

  assign state   = state_q;
  assign duty    = duty_q;
  assign dir     = dir_q;
  assign flag    = flag_q;
  assign adc_req = adc_req_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mppt_po_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mppt_po_sequencer
// Brief   : Self-checking bench. Instance 0 uses default duty limits with a
//           short settle; instance 1 starts near the upper clamp. Expected
//           values come from an arithmetic P&O reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mppt_po_sequencer;

  localparam int DW       = 12;
  localparam int DUTY_W   = 10;
  localparam int STEP     = 4;
  localparam int DUTY_MIN = 64;
  localparam int DEADBAND = 16;
`ifdef MPPT_DEADBAND_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst       [2];
  logic              en        [2];
  logic [DW-1:0]     adc_v     [2];
  logic [DW-1:0]     adc_i     [2];
  logic              adc_valid [2];
  logic              adc_req_o [2];
  logic [DUTY_W-1:0] duty_o    [2];
  logic              dir_o     [2];
  logic [2:0]        state_o   [2];
  logic [1:0]        flag_o    [2];
  logic              busy_o    [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state per instance
  int     m_duty  [2];
  int     m_dir   [2];
  int     m_flag  [2];
  int     m_first [2];
  longint m_pprev [2];

  always #5 clk = ~clk;

  mppt_po_sequencer #(.SETTLE(3)) u_dut0 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .adc_v(adc_v[0]), .adc_i(adc_i[0]),
    .adc_valid(adc_valid[0]), .adc_req(adc_req_o[0]), .duty(duty_o[0]),
    .dir(dir_o[0]), .state(state_o[0]), .flag(flag_o[0]), .busy(busy_o[0])
  );

  mppt_po_sequencer #(.DUTY_INIT(956), .DUTY_MAX(958), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .adc_v(adc_v[1]), .adc_i(adc_i[1]),
    .adc_valid(adc_valid[1]), .adc_req(adc_req_o[1]), .duty(duty_o[1]),
    .dir(dir_o[1]), .state(state_o[1]), .flag(flag_o[1]), .busy(busy_o[1])
  );

  function automatic int init_of(input int s);
    return (s == 0) ? 512 : 956;
  endfunction

  function automatic int max_of(input int s);
    return (s == 0) ? 960 : 958;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int s);
    m_duty[s]  = init_of(s);
    m_dir[s]   = 1;
    m_flag[s]  = 0;
    m_first[s] = 1;
    m_pprev[s] = 0;
  endtask

  // One P&O iteration expressed directly from the tracking rules.
  task automatic model_iter(input int s, input int v, input int i);
    longint p;
    longint d;
    int     target;
    bit     move;
    p    = longint'(v) * longint'(i);
    move = 1'b1;
    if (m_first[s] != 0) begin
      m_flag[s]  = 0;
      m_first[s] = 0;
    end else begin
      d = p - m_pprev[s];
      if (d < 0) d = -d;
      if (DB_ON && d <= DEADBAND) m_flag[s] = 0;
      else if (p > m_pprev[s]) m_flag[s] = 1;
      else if (p < m_pprev[s]) begin
        m_flag[s] = 2;
        m_dir[s]  = 1 - m_dir[s];
      end else m_flag[s] = 0;
      move = (m_flag[s] != 0);
    end
    if (move) begin
      target = m_duty[s] + ((m_dir[s] != 0) ? STEP : -STEP);
      if (target > max_of(s)) begin
        m_duty[s] = max_of(s);
        m_dir[s]  = 0;
      end else if (target < DUTY_MIN) begin
        m_duty[s] = DUTY_MIN;
        m_dir[s]  = 1;
      end else begin
        m_duty[s] = target;
      end
    end
    m_pprev[s] = p;
  endtask

  task automatic check_reset(input int s);
    check("rst_state",   state_o[s],   0);
    check("rst_duty",    duty_o[s],    init_of(s));
    check("rst_flag",    flag_o[s],    0);
    check("rst_dir",     dir_o[s],     1);
    check("rst_adc_req", adc_req_o[s], 0);
    check("rst_busy",    busy_o[s],    0);
  endtask

  // Bounded wait (sampled on rising edges) for a given FSM state.
  task automatic wait_state(input int s, input int st, input int budget, input string tag);
    int n;
    n = 0;
    while (state_o[s] !== 3'(st) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(tag, state_o[s], st);
  endtask

  // Full iteration: REQ handshake, sample delivery, then duty/flag/dir checks.
  task automatic iter(input int s, input int v, input int i);
    wait_state(s, 1, 40, "wait_req");
    check("req_pulse", adc_req_o[s], 1);
    check("req_busy",  busy_o[s],    1);
    @(posedge clk);
    check("wait_adc_state", state_o[s],   2);
    check("req_one_cycle",  adc_req_o[s], 0);
    adc_v[s]     = DW'(v);
    adc_i[s]     = DW'(i);
    adc_valid[s] = 1'b1;
    @(posedge clk);
    adc_valid[s] = 1'b0;
    check("calc_state", state_o[s], 3);
    @(posedge clk);
    @(posedge clk);
    check("update_state", state_o[s], 5);
    check("duty_latency", duty_o[s],  m_duty[s]);
    model_iter(s, v, i);
    @(posedge clk);
    check("settle_state", state_o[s], 6);
    check("flag",         flag_o[s],  m_flag[s]);
    check("dir",          dir_o[s],   m_dir[s]);
    check("duty",         duty_o[s],  m_duty[s]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; en[s] = 1'b0; adc_v[s] = '0; adc_i[s] = '0; adc_valid[s] = 1'b0;
      model_reset(s);
    end
    @(posedge clk); @(posedge clk); @(posedge clk);
    check_reset(0);
    check_reset(1);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk);
    check("idle_hold", state_o[0], 0);

    // First sample, climb, then reversal
    en[0] = 1'b1;
    iter(0, 100, 100);
    iter(0, 100, 110);
    iter(0, 100, 90);

    // Abort in WAIT_ADC, ignored late strobe, resume from retained p_prev
    wait_state(0, 1, 40, "abort_req");
    @(posedge clk);
    check("abort_wait", state_o[0], 2);
    en[0] = 1'b0;
    @(posedge clk);
    check("abort_idle",  state_o[0], 0);
    check("abort_duty",  duty_o[0],  m_duty[0]);
    check("abort_busy",  busy_o[0],  0);
    check("abort_req_o", adc_req_o[0], 0);
    @(posedge clk);
    adc_v[0] = 12'd4000; adc_i[0] = 12'd4000; adc_valid[0] = 1'b1;
    @(posedge clk);
    adc_valid[0] = 1'b0;
    @(posedge clk);
    check("late_valid_state", state_o[0], 0);
    check("late_valid_duty",  duty_o[0],  m_duty[0]);
    check("late_valid_dir",   dir_o[0],   m_dir[0]);
    check("late_valid_flag",  flag_o[0],  m_flag[0]);
    en[0] = 1'b1;
    @(posedge clk);
    check("reenable_req", state_o[0], 1);
    iter(0, 100, 100);

    // Near-deadband sample: p_prev = 10000, p = 10010
    iter(0, 10, 1001);

    // Randomized iterations: small operands make equal powers common
    for (int k = 0; k < 24; k++) begin
      int v, i;
      if (k % 3 == 0) begin
        v = int'($urandom_range(0, 4095));
        i = int'($urandom_range(0, 4095));
      end else begin
        v = int'($urandom_range(1, 6));
        i = int'($urandom_range(1, 6));
      end
      iter(0, v, i);
    end

    // Reset mid-conversion, then a fresh first sample
    wait_state(0, 1, 40, "midrst_req");
    @(posedge clk);
    check("midrst_wait", state_o[0], 2);
    rst[0] = 1'b1;
    @(posedge clk);
    model_reset(0);
    check_reset(0);
    rst[0] = 1'b0;
    iter(0, 50, 50);

    // Upper clamp on instance 1
    en[1] = 1'b1;
    iter(1, 100, 100);
    iter(1, 100, 110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mppt_po_sequencer.md
Name: mppt_po_sequencer

Overview:
- Perturb-and-observe MPPT controller that drives the converter duty cycle.
- Each iteration it requests an ADC conversion, captures V and I, and computes P = V*I.
- It compares P with the previous sample, picks the perturbation direction and steps the duty with saturation, then waits a settle interval.
- Exports its 3-bit FSM state and a 2-bit comparison flag for the shared state/flag register and for debug.

Parameters:
- DW, 12, ADC sample width for V and I.
- DUTY_W, 10, duty word width.
- DUTY_INIT, 512, duty value after reset.
- DUTY_MIN, 64, lower duty clamp.
- DUTY_MAX, 960, upper duty clamp.
- STEP, 4, duty perturbation per iteration.
- SETTLE, 255, falling edges spent in SETTLE after each duty update; must be at least 1.
- DEADBAND, 16, power tolerance; used only with MPPT_DEADBAND_EN.

Ports:
- clk  in  1  system clock; all registers update on the falling edge.
- rst  in  1  reset: rst, synchronous, active-high.
- en  in  1  tracking enable.
- adc_v  in  DW  voltage sample.
- adc_i  in  DW  current sample.
- adc_valid  in  1  one-cycle strobe; adc_v and adc_i are valid in that cycle.
- adc_req  out  1  one-cycle conversion request.
- duty  out  DUTY_W  registered duty command.
- dir  out  1  perturbation direction; 1 = increase.
- state  out  3  current FSM state.
- flag  out  2  last comparison: 00 = equal or first sample, 01 = power rose, 10 = power fell; 11 is never produced.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - state = IDLE (0), duty = DUTY_INIT, dir = 1, flag = 00.
  - adc_req = 0, busy = 0, p_prev = 0, first = 1, settle counter = 0.
- States (encoding): IDLE = 0, REQ = 1, WAIT_ADC = 2, CALC = 3, COMPARE = 4, UPDATE = 5, SETTLE = 6. Encoding 7 is unused and returns to IDLE on the next edge.
- IDLE: go to REQ when en = 1.
- REQ: adc_req = 1 for exactly this one cycle; then go to WAIT_ADC.
- WAIT_ADC: no timeout. On adc_valid = 1, capture v and i and go to CALC.
- CALC: p = v*i, full 2*DW bits unsigned, registered; go to COMPARE.
- COMPARE:
  - If first = 1: flag = 00, dir unchanged, clear first.
  - Else if p > p_prev: flag = 01, dir unchanged.
  - Else if p < p_prev: flag = 10, dir inverted.
  - Else (p = p_prev): flag = 00, dir unchanged.
  - Go to UPDATE.
- UPDATE:
  - Step duty by STEP in direction dir, except no step when flag = 00 and first was already cleared before this iteration.
  - Clamp the result to [DUTY_MIN, DUTY_MAX], computing in DUTY_W+1 bits so the sum or difference cannot wrap.
  - If the clamp engaged, force dir toward the interior: dir = 0 at DUTY_MAX, dir = 1 at DUTY_MIN.
  - Set p_prev = p, load the settle counter with SETTLE, go to SETTLE.
- SETTLE: decrement the counter each edge. At 0, go to REQ if en = 1, else go to IDLE.
- Latency: duty changes on the 3rd falling edge after the edge that captures adc_valid (CALC, COMPARE, UPDATE).
- en = 0 in any non-IDLE state:
  - Next state is IDLE; adc_req is forced to 0.
  - duty, dir, p_prev and first are held.
  - A late adc_valid is ignored.
  - Re-enabling continues tracking from p_prev.
- Exception: en falling while in UPDATE still completes that cycle's duty write, then goes to IDLE.
- adc_valid outside WAIT_ADC is ignored.
- rst has priority over every other input and returns all outputs to their reset values on the next falling edge, including mid-conversion.

Optional Feature:
- Macro: MPPT_DEADBAND_EN.
- Defined: in COMPARE, |p - p_prev| <= DEADBAND is treated as equal (flag 00, no step, dir unchanged). Outside the band, the normal > / < rules apply.
- Not defined: exact comparison only, and the DEADBAND parameter is unused.

Test Plan:
- Reset: assert rst for 2 edges -> duty = 512, state = 0, flag = 00, dir = 1, adc_req = 0, busy = 0.
- First iteration: en = 1 -> adc_req high exactly one cycle, state 1 -> 2. Then adc_valid with V = 100, I = 100 -> p = 10000, flag = 00, duty = 516 three edges later, state reaches 6.
- Climb then reverse (SETTLE = 3):
  - V = 100, I = 110 -> flag = 01, dir = 1, duty = 520.
  - Next, V = 100, I = 90 -> flag = 10, dir = 0, duty = 516.
- Clamp: DUTY_INIT = 956, DUTY_MAX = 958, two rising-power samples:
  - Iteration 1 -> duty = 958, clamp engaged, dir forced 0.
  - Iteration 2 -> flag = 01 with dir = 0 -> duty = 954, no wrap.
- Abort: drop en while in WAIT_ADC -> state = 0 next edge, duty unchanged. An adc_valid pulse 2 cycles later changes nothing. Re-enable -> state = 1 and comparison uses the retained p_prev.
- Deadband (macro defined, DEADBAND = 16): p_prev = 10000, new p = 10010 -> flag = 00, duty unchanged. Same stimulus without the macro -> flag = 01, duty steps by 4.
